// File: rtl/ml_requant_pack.sv
// Requantizes signed accumulators to int8 (round half up, arithmetic shift, saturate) and packs 1..4 lanes per 32-bit word.
// Optional build macro ML_REQUANT_RELU_EN clamps negative results to zero.
module ml_requant_pack #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_acc,
    input  logic                    in_last,
    input  logic [4:0]              shift,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic [2:0]              out_bytes,
    output logic [CNT_W-1:0]        sat_count,
    input  logic                    sat_clr
);

    typedef enum logic {EMPTY, PARTIAL} lane_state_t;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(127);
`ifndef ML_REQUANT_RELU_EN
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-128);
`endif

    lane_state_t state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] partial_q, partial_d;
    logic [31:0] word_d;

    logic signed [ACC_W:0] ext, rnd_add, rounded, shifted;
    logic [7:0]            lane_byte;
    logic                  sat_event;
    logic                  accept, complete;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign complete = accept & (in_last | (cnt_q == 2'd3));

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        ext       = {in_acc[ACC_W-1], in_acc};
        rnd_add   = '0;
        if (shift != 5'd0)
            rnd_add = (ACC_W+1)'(1) << (shift - 5'd1);
        rounded   = ext + rnd_add;
        shifted   = rounded >>> shift;
        lane_byte = shifted[7:0];
        sat_event = 1'b0;
`ifdef ML_REQUANT_RELU_EN
        if (shifted[ACC_W]) begin
            lane_byte = 8'h00;
        end else if (shifted > SAT_MAX) begin
            lane_byte = 8'h7f;
            sat_event = 1'b1;
        end
`else
        if (shifted > SAT_MAX) begin
            lane_byte = 8'h7f;
            sat_event = 1'b1;
        end else if (shifted < SAT_MIN) begin
            lane_byte = 8'h80;
            sat_event = 1'b1;
        end
`endif
    end

    // Lanes above cnt are always zero in partial_q, so OR-ing the new byte in is enough.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        partial_d = partial_q;
        word_d    = {8'h00, partial_q} | (32'(lane_byte) << {cnt_q, 3'b000});
        if (accept) begin
            if (complete) begin
                cnt_d     = 2'd0;
                partial_d = '0;
            end else begin
                cnt_d     = cnt_q + 2'd1;
                partial_d = partial_q | (24'(lane_byte) << {cnt_q, 3'b000});
            end
        end
        case (state_q)
            EMPTY:   if (accept && !complete) state_d = PARTIAL;
            PARTIAL: if (complete)            state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= EMPTY;
            cnt_q     <= 2'd0;
            partial_q <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            sat_count <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
            if (complete) begin
                out_valid <= 1'b1;
                out_data  <= word_d;
                out_bytes <= {1'b0, cnt_q} + 3'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (sat_clr)
                sat_count <= '0;
            else if (accept && sat_event && (sat_count != '1))
                sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ml_requant_pack.sv
// Scoreboard bench for ml_requant_pack: real-arithmetic reference model, random and directed stimulus.
module tb_ml_requant_pack;

    localparam int ACC_W   = 32;
    localparam int CNT_W   = 16;
    localparam int SAT_TOP = (1 << CNT_W) - 1;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  in_acc;
    logic              in_last;
    logic [4:0]        shift;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [2:0]        out_bytes;
    logic [CNT_W-1:0]  sat_count;
    logic              sat_clr;

    ml_requant_pack #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
        .in_last(in_last), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_bytes(out_bytes),
        .sat_count(sat_count), .sat_clr(sat_clr)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] mdl_bytes[$];
    int         mdl_sat;
    int         n_pass  = 0;
    int         n_total = 0;
    bit         rnd_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Round half up is floor(x/2^s + 1/2); doubles hold these values exactly.
    function automatic logic [7:0] model_quant(input int acc, input int sh, output bit sat);
        real   r;
        longint v;
        r   = real'(acc) / (2.0 ** sh);
        v   = longint'($floor(r + 0.5));
        sat = 1'b0;
`ifdef ML_REQUANT_RELU_EN
        if (v < 0) v = 0;
        else if (v > 127) begin v = 127; sat = 1'b1; end
`else
        if (v > 127) begin v = 127; sat = 1'b1; end
        else if (v < -128) begin v = -128; sat = 1'b1; end
`endif
        return v[7:0];
    endfunction

    task automatic model_accept(input int acc, input bit last, input int sh);
        bit         sat;
        logic [7:0] b;
        word_t      w;
        b = model_quant(acc, sh, sat);
        if (sat && mdl_sat < SAT_TOP) mdl_sat++;
        mdl_bytes.push_back(b);
        if (last || mdl_bytes.size() == 4) begin
            w.data  = '0;
            for (int i = 0; i < mdl_bytes.size(); i++) w.data[8*i +: 8] = mdl_bytes[i];
            w.bytes = 3'(mdl_bytes.size());
            exp_q.push_back(w);
            mdl_bytes.delete();
        end
    endtask

    // Called and returns at posedge+2; readiness is judged at posedge+3.
    task automatic send(input int acc, input bit last, input int sh);
        int budget = 0;
        in_valid = 1'b1;
        in_acc   = ACC_W'(acc);
        in_last  = last;
        shift    = sh[4:0];
        #1;
        while (!in_ready && budget < 1000) begin
            @(posedge HCLK); #3;
            budget++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            @(posedge HCLK); #2;
        end else begin
            model_accept(acc, last, sh);
            @(posedge HCLK); #2;
            in_valid = 1'b0;
            in_acc   = ACC_W'($urandom);
            in_last  = 1'($urandom);
            shift    = 5'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge HCLK); #2; end
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin idle(1); budget++; end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        word_t w;
        forever begin
            @(negedge HCLK);
            if (!HRESET && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got 0x%08h expected no word", out_data);
                end else begin
                    w = exp_q.pop_front();
                    check("word_data", out_data, w.data);
                    check("word_bytes", 32'(out_bytes), 32'(w.bytes));
                end
            end
        end
    end

    initial begin
        logic [31:0] held;
        int          budget;
        HRESET = 1'b1; in_valid = 1'b0; in_acc = '0; in_last = 1'b0; shift = '0;
        out_ready = 1'b1; sat_clr = 1'b0; mdl_sat = 0;
        repeat (3) @(posedge HCLK);
        #2 HRESET = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_out_bytes", 32'(out_bytes), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);

        for (int i = 1; i <= 4; i++) send(i, 1'b0, 0);
        check("pack4_latency", 32'(out_valid), 32'd1);
        check("pack4_data",    out_data, 32'h04030201);
        check("pack4_bytes",   32'(out_bytes), 32'd4);
        idle(1);

        send(32'h17, 1'b0, 4);
        send(32'h18, 1'b0, 4);
        send(-24,    1'b1, 4);
        check("round_data", out_data, 32'h00FF0201);
        idle(1);

        sat_clr = 1'b1; idle(1); sat_clr = 1'b0; mdl_sat = 0;
        send(1000,  1'b0, 0);
        send(-1000, 1'b1, 0);
`ifdef ML_REQUANT_RELU_EN
        check("sat_data",  out_data, 32'h0000007F);
        check("sat_count2", 32'(sat_count), 32'd1);
`else
        check("sat_data",  out_data, 32'h0000807F);
        check("sat_count2", 32'(sat_count), 32'd2);
`endif
        check("sat_bytes", 32'(out_bytes), 32'd2);
        check("sat_model", 32'(sat_count), 32'(mdl_sat));
        idle(1);

        for (int i = 0; i < 4; i++) send(16 + i, 1'b0, 0);
        idle(1);
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 9; i++) send(32 + i, i == 8, 0);
        join_none
        budget = 0;
        while (!out_valid && budget < 50) begin idle(1); budget++; end
        check("bp_word2_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        held = out_data;
        idle(5);
        check("bp_data_stable", out_data, held);
        check("bp_still_blocked", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        wait fork;
        drain();

        send(11, 1'b0, 0);
        send(12, 1'b0, 0);
        HRESET = 1'b1; idle(1); HRESET = 1'b0;
        mdl_bytes.delete(); exp_q.delete(); mdl_sat = 0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready), 32'd1);
        check("midrst_sat",       32'(sat_count), 32'd0);
        for (int i = 5; i <= 8; i++) send(i, 1'b0, 0);
        check("midrst_data", out_data, 32'h08070605);
        drain();

        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge HCLK); #2;
                out_ready = ($urandom_range(0, 2) != 0);
            end
        join_none
        for (int i = 0; i < 400; i++) begin
            int acc, sh, sel;
            sel = $urandom_range(0, 2);
            if (sel == 0) begin acc = int'($urandom); sh = $urandom_range(0, 31); end
            else if (sel == 1) begin acc = int'($urandom_range(0, 600)) - 300; sh = $urandom_range(0, 3); end
            else begin acc = int'($urandom_range(0, 40000)) - 20000; sh = $urandom_range(6, 10); end
            send(acc, $urandom_range(0, 3) == 0, sh);
        end
        rnd_on = 1'b0;
        idle(2);
        out_ready = 1'b1;
        send(1, 1'b1, 0);
        drain();
        check("rnd_sat_model", 32'(sat_count), 32'(mdl_sat));

        sat_clr = 1'b1; idle(1); sat_clr = 1'b0; mdl_sat = 0;
        for (int i = 0; i < SAT_TOP; i++) send(1000, 1'b0, 0);
        check("satcnt_full", 32'(sat_count), 32'h0000FFFF);
        send(1000, 1'b0, 0);
        check("satcnt_nowrap", 32'(sat_count), 32'h0000FFFF);
        sat_clr = 1'b1;
        send(1000, 1'b0, 0);
        sat_clr = 1'b0; mdl_sat = 0;
        check("satcnt_clr_prio", 32'(sat_count), 32'd0);
        send(0, 1'b1, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
